// File: rtl/multiplier_fxp.sv
// Multi-cycle sign-magnitude shift-add fixed-point multiplier, BITS_PER_CYC multiplier bits per cycle.
// Define MUL_FXP_SAT_EN to saturate on overflow and raise O_OVF; otherwise the product wraps.
module multiplier_fxp #(
  parameter int DATA_W       = 16,
  parameter int FRAC_W       = 13,
  parameter int BITS_PER_CYC = 4
) (
  input  logic              I_CLK,
  input  logic              I_RST_N,
  input  logic              I_VLD,
  input  logic [DATA_W-1:0] I_M1,
  input  logic [DATA_W-1:0] I_M2,
  output logic              O_VLD,
  output logic              O_MUL_BUSY,
  output logic [DATA_W-1:0] O_PRODUCT,
  output logic              O_OVF
);
  localparam int ITER  = DATA_W / BITS_PER_CYC;
  localparam int ACC_W = 2 * DATA_W;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  if (DATA_W % BITS_PER_CYC != 0) begin : g_bad_cfg
    $error("multiplier_fxp: DATA_W must be a multiple of BITS_PER_CYC");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] m1_q, m1_d, m2_q, m2_d;
  logic              sign_q, sign_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              vld_q, vld_d, ovf_q, ovf_d;
  logic [DATA_W-1:0] prod_q, prod_d;

  logic [DATA_W-1:0]              abs1, abs2, slice, res;
  logic [DATA_W+BITS_PER_CYC-1:0] partial;
  logic [ACC_W-1:0]               p_full;
  logic                           ovf_c;
  logic                           unused_p;

  // Negating the most negative value yields 2^(DATA_W-1), exact as unsigned.
  assign abs1 = I_M1[DATA_W-1] ? -I_M1 : I_M1;
  assign abs2 = I_M2[DATA_W-1] ? -I_M2 : I_M2;

  assign partial = {{BITS_PER_CYC{1'b0}}, m1_q} * {{DATA_W{1'b0}}, m2_q[BITS_PER_CYC-1:0]};

  assign p_full   = sign_q ? -acc_q : acc_q;
  assign slice    = {p_full[ACC_W-1], p_full[DATA_W+FRAC_W-2:FRAC_W]};
  assign unused_p = ^p_full;

`ifdef MUL_FXP_SAT_EN
  logic [DATA_W-FRAC_W:0] top;
  // Bits above the kept field must all match the sign, else the result does not fit.
  assign top   = p_full[ACC_W-1:DATA_W+FRAC_W-1];
  assign ovf_c = ~((&top) | ~(|top));
  assign res   = !ovf_c ? slice :
                 p_full[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`else
  assign ovf_c = 1'b0;
  assign res   = slice;
`endif

  always_comb begin
    state_d = state_q;
    m1_d    = m1_q;
    m2_d    = m2_q;
    sign_d  = sign_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    vld_d   = 1'b0;
    prod_d  = prod_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) begin
          vld_d  = 1'b1;
          prod_d = res;
          ovf_d  = ovf_c;
        end
        state_d = IDLE;
        if (I_VLD) begin
          m1_d    = abs1;
          m2_d    = abs2;
          sign_d  = I_M1[DATA_W-1] ^ I_M2[DATA_W-1];
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_q + (ACC_W'(partial) << (cnt_q * BITS_PER_CYC));
        m2_d  = m2_q >> BITS_PER_CYC;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITER - 1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q <= IDLE;
      m1_q    <= '0;
      m2_q    <= '0;
      sign_q  <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      prod_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m1_q    <= m1_d;
      m2_q    <= m2_d;
      sign_q  <= sign_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      prod_q  <= prod_d;
      ovf_q   <= ovf_d;
    end
  end

  assign O_VLD      = vld_q;
  assign O_MUL_BUSY = (state_q == CALC);
  assign O_PRODUCT  = prod_q;
  assign O_OVF      = ovf_q;
endmodule

// File: tb/tb_multiplier_fxp.sv
// Self-checking bench: directed vectors and corner sequences on the default build,
// plus randomized traffic on both the default and a 24/16/8 instance.
module tb_multiplier_fxp;
  localparam int WB = 24;
  localparam int FB = 16;
  localparam int NR = 10000;
`ifdef MUL_FXP_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          vld_a = 1'b0;
  logic [15:0]   m1_a = '0, m2_a = '0;
  logic          ovld_a, busy_a, ovf_a;
  logic [15:0]   prod_a;
  logic          vld_b = 1'b0;
  logic [WB-1:0] m1_b = '0, m2_b = '0;
  logic          ovld_b, busy_b, ovf_b;
  logic [WB-1:0] prod_b;

  multiplier_fxp u_a (
    .I_CLK(clk), .I_RST_N(rst_n), .I_VLD(vld_a), .I_M1(m1_a), .I_M2(m2_a),
    .O_VLD(ovld_a), .O_MUL_BUSY(busy_a), .O_PRODUCT(prod_a), .O_OVF(ovf_a)
  );

  multiplier_fxp #(.DATA_W(WB), .FRAC_W(FB), .BITS_PER_CYC(8)) u_b (
    .I_CLK(clk), .I_RST_N(rst_n), .I_VLD(vld_b), .I_M1(m1_b), .I_M2(m2_b),
    .O_VLD(ovld_b), .O_MUL_BUSY(busy_b), .O_PRODUCT(prod_b), .O_OVF(ovf_b)
  );

  int total = 0;
  int bad   = 0;

  typedef struct { logic [15:0] m1, m2, p; logic o; } vec_t;
  typedef struct { longint unsigned p; bit o; } exp_t;
  vec_t vecs[10];
  exp_t qa[$], qb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Floor of the full signed product scaled by 2^-f, then wrapped or saturated to w bits.
  function automatic void ref_mul(input int w, input int f, input longint unsigned a,
                                  input longint unsigned b, output longint unsigned p, output bit o);
    longint sa, sb, full, q, hi, lo;
    sa = $signed(a << (64 - w));
    sa = sa >>> (64 - w);
    sb = $signed(b << (64 - w));
    sb = sb >>> (64 - w);
    full = sa * sb;
    q  = full >>> f;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    o  = 1'b0;
    if (SAT) begin
      if (q > hi) begin p = longint'(hi); o = 1'b1; end
      else if (q < lo) begin p = 64'd1 << (w - 1); o = 1'b1; end
      else p = q & ((64'd1 << w) - 1);
    end else begin
      p = q & ((64'd1 << (w - 1)) - 1);
      if (full < 0) p = p | (64'd1 << (w - 1));
    end
  endfunction

  function automatic longint unsigned rnd(input int w, input int f);
    case ($urandom_range(0, 7))
      0:       return 64'd1 << (w - 1);
      1:       return (64'd1 << (w - 1)) - 1;
      2:       return (64'd1 << w) - 1;
      3:       return 64'd1 << f;
      default: return {$urandom, $urandom} & ((64'd1 << w) - 1);
    endcase
  endfunction

  // Call at #1 after an edge; returns at #1 after the edge that sampled I_VLD.
  task automatic issue_a(input logic [15:0] a, input logic [15:0] b);
    vld_a = 1'b1; m1_a = a; m2_a = b;
    @(posedge clk); #1;
    vld_a = 1'b0;
  endtask

  task automatic issue_b(input logic [WB-1:0] a, input logic [WB-1:0] b);
    vld_b = 1'b1; m1_b = a; m2_b = b;
    @(posedge clk); #1;
    vld_b = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n, nb;
    string s;
    s = $sformatf("vec%0d", idx);
    issue_a(v.m1, v.m2);
    nb = busy_a;
    n  = 0;
    while (!ovld_a && n < 12) begin
      @(posedge clk); #1;
      n++;
      if (!ovld_a) nb += busy_a;
    end
    chk({s, "_latency"}, n, 5);
    chk({s, "_busy_cycles"}, nb, 4);
    chk({s, "_prod"}, prod_a, v.p);
    chk({s, "_ovf"}, ovf_a, v.o);
    @(posedge clk); #1;
    chk({s, "_vld_pulse"}, ovld_a, 0);
    chk({s, "_prod_hold"}, prod_a, v.p);
  endtask

  logic [15:0]   ra1, ra2, got_p;
  logic [WB-1:0] rb1, rb2;
  exp_t ea, eb, ma, mb;
  int cnt, n, ga, gb, ca, cb;

  initial begin
    vecs[0] = '{16'h2000, 16'h2000, 16'h2000, 1'b0};
    vecs[1] = '{16'hE000, 16'h2000, 16'hE000, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0001, 16'hFFFF, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h7FFF, SAT ? 16'h7FFF : 16'h7FF8, SAT};
    vecs[4] = '{16'h8000, 16'h8000, SAT ? 16'h7FFF : 16'h0000, SAT};
    vecs[5] = '{16'h4000, 16'h4000, SAT ? 16'h7FFF : 16'h0000, SAT};
    vecs[6] = '{16'h6000, 16'hC000, SAT ? 16'h8000 : 16'hC000, SAT};
    vecs[7] = '{16'h8000, 16'h2000, 16'h8000, 1'b0};
    vecs[8] = '{16'hFFFF, 16'hFFFF, 16'h0000, 1'b0};
    vecs[9] = '{16'h1234, 16'h0002, 16'h0001, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_vld_a", ovld_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_prod_a", prod_a, 0);
    chk("rst_ovf_a", ovf_a, 0);
    chk("rst_vld_b", ovld_b, 0);
    chk("rst_prod_b", prod_b, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // I_VLD while busy is dropped: exactly one pulse carrying the first result.
    issue_a(16'h2000, 16'h2000);
    @(posedge clk); #1;
    vld_a = 1'b1; m1_a = 16'h1234; m2_a = 16'h0002;
    @(posedge clk); #1;
    vld_a = 1'b0;
    cnt = 0; got_p = '0;
    repeat (12) begin
      @(posedge clk); #1;
      if (ovld_a) begin cnt++; got_p = prod_a; end
    end
    chk("busy_drop_pulses", cnt, 1);
    chk("busy_drop_prod", got_p, 16'h2000);

    // Issue in the DONE cycle is accepted.
    issue_a(16'hE000, 16'h2000);
    repeat (4) @(posedge clk);
    #1;
    chk("done_busy", busy_a, 0);
    issue_a(16'hC000, 16'h2000);
    chk("b2b_first_vld", ovld_a, 1);
    chk("b2b_first_prod", prod_a, 16'hE000);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ovld_a && n < 12);
    chk("b2b_second_latency", n, 5);
    chk("b2b_second_prod", prod_a, 16'hC000);

    // Reset mid-CALC aborts with no O_VLD.
    issue_a(16'h2000, 16'h2000);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy_a, 0);
    chk("midrst_vld", ovld_a, 0);
    chk("midrst_prod", prod_a, 0);
    chk("midrst_ovf", ovf_a, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ovld_a) cnt++;
    end
    chk("midrst_no_vld", cnt, 0);
    run_vec(vecs[0], 100);

    // Random traffic on both instances, issue period alternating 6 and 7 cycles.
    ga = 0; gb = 0; ca = 0; cb = 0;
    fork
      begin
        for (int i = 0; i < NR; i++) begin
          ra1 = 16'(rnd(16, 13)); ra2 = 16'(rnd(16, 13));
          ref_mul(16, 13, 64'(ra1), 64'(ra2), ea.p, ea.o);
          qa.push_back(ea);
          issue_a(ra1, ra2);
          repeat ((i % 2) ? 6 : 5) @(posedge clk);
          #1;
        end
      end
      begin
        for (int i = 0; i < NR; i++) begin
          rb1 = WB'(rnd(WB, FB)); rb2 = WB'(rnd(WB, FB));
          ref_mul(WB, FB, 64'(rb1), 64'(rb2), eb.p, eb.o);
          qb.push_back(eb);
          issue_b(rb1, rb2);
          repeat ((i % 2) ? 5 : 6) @(posedge clk);
          #1;
        end
      end
      begin
        while (ga < NR && ca < NR * 7 + 100) begin
          @(negedge clk);
          ca++;
          if (ovld_a) begin
            ga++;
            if (qa.size() == 0) chk("rand_a_extra_vld", 1, 0);
            else begin
              ma = qa.pop_front();
              chk("rand_a_prod", prod_a, ma.p);
              chk("rand_a_ovf", ovf_a, ma.o);
            end
          end
        end
        chk("rand_a_count", ga, NR);
      end
      begin
        while (gb < NR && cb < NR * 7 + 100) begin
          @(negedge clk);
          cb++;
          if (ovld_b) begin
            gb++;
            if (qb.size() == 0) chk("rand_b_extra_vld", 1, 0);
            else begin
              mb = qb.pop_front();
              chk("rand_b_prod", prod_b, mb.p);
              chk("rand_b_ovf", ovf_b, mb.o);
            end
          end
        end
        chk("rand_b_count", gb, NR);
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
